scan_frame_ctrl: RTL

//  Frame controller feeding a word stream, bit-serially, into the team's single-bit 1011 Moore detector
//  (detector clocks every cycle, no enable; hit output is valid one cycle after the bit is presented).

---
 rtl/scan_frame_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/scan_frame_ctrl.sv
// Frame controller: accepts words over valid/ready, serializes them gap-free
// into a 1011 Moore detector, clears the detector at frame start and counts
// detector hits per frame with a saturating counter.
// Optional build macro: SCAN_IRQ_EN adds a sticky irq output with irq_clr input.
module scan_frame_ctrl #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              cfg_lsb_first,
  output logic              det_reset,
  output logic              det_bit,
  input  logic              det_hit,
  output logic [CNT_W-1:0]  hit_count,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
`ifdef SCAN_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_clr
`endif
);

  localparam int unsigned IDX_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WORD_W-1:0] sreg_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              last_q;
  logic              order_q;
  logic              bit_vld_q;
  logic              at_end;
  logic              accept;
  logic              underrun;

  // First bit of a word in the selected order
  function automatic logic first_bit(input logic [WORD_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[WORD_W-1];
  endfunction

  // Word with its first bit consumed
  function automatic logic [WORD_W-1:0] shift_word(input logic [WORD_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[WORD_W-1:1]} : {w[WORD_W-2:0], 1'b0};
  endfunction

  assign at_end   = (bit_idx_q == LAST_IDX);
  // Ready decodes from registered state only
  assign in_ready = (state_q == CLR) || ((state_q == SHIFT) && at_end && !last_q);
  assign busy     = (state_q != IDLE);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode, word acceptance and underrun detection
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    underrun = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = CLR;
      end
      CLR: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (at_end) begin
          if (last_q) begin
            state_d = DRAIN;
          end else if (in_valid) begin
            accept  = 1'b1;
            state_d = SHIFT;
          end else begin
            underrun = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Serializer, detector control and frame status flops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sreg_q     <= '0;
      bit_idx_q  <= '0;
      last_q     <= 1'b0;
      order_q    <= 1'b0;
      bit_vld_q  <= 1'b0;
      det_reset  <= 1'b1;
      det_bit    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      det_reset  <= (state_d == CLR);
      frame_done <= (state_d == DONE);
      frame_err  <= underrun;
      bit_vld_q  <= (state_q == SHIFT);
      if (accept) begin
        order_q   <= cfg_lsb_first;
        last_q    <= in_last;
        det_bit   <= first_bit(in_data, cfg_lsb_first);
        sreg_q    <= shift_word(in_data, cfg_lsb_first);
        bit_idx_q <= '0;
      end else if ((state_q == SHIFT) && (state_d == SHIFT)) begin
        det_bit   <= first_bit(sreg_q, order_q);
        sreg_q    <= shift_word(sreg_q, order_q);
        bit_idx_q <= bit_idx_q + IDX_W'(1);
      end else begin
        det_bit   <= 1'b0;
      end
    end
  end

  // Saturating per-frame hit counter; held until next frame start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count <= '0;
    end else if (state_q == CLR) begin
      hit_count <= '0;
    end else if (bit_vld_q && det_hit && (hit_count != {CNT_W{1'b1}})) begin
      hit_count <= hit_count + CNT_W'(1);
    end
  end

`ifdef SCAN_IRQ_EN
  // Sticky interrupt; set wins over a coincident clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if ((state_q == DONE) && ((hit_count != '0) || frame_err)) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
